systolic_mac_driver: RTL and testbench
======================================

Name: systolic_mac_driver

Overview:
- Initiator side of the systolic-array MAC port: owns and drives start, count, weight, in_value and in_accumulate into one MAC processing element, and captures that element's out_accumulate.
- Preloads and holds a stationary weight, then accepts operand pairs through a valid/ready handshake.
- Sequences each MAC operation through a fixed-latency window and returns the accumulated FP16 result through a valid/ready handshake.
- Used by the array controller and by PE-level testbenches as the canonical driver of one PE.

Parameters:
- DATA_W, 16: operand/result width (FP16 bit pattern, never interpreted by this block).
- MAC_LAT, 3: number of cycles count stays high per operation; legal range 1..15.
- CNT_W, 16: width of the optional operation counter.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- w_wr  in  1  weight write strobe.
- w_data  in  DATA_W  weight to preload.
- w_err  out  1  one-cycle pulse: weight write rejected because the block is busy.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  block can accept an operand pair.
- op_value  in  DATA_W  multiplicand.
- op_acc  in  DATA_W  partial sum from above.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_W  captured out_accumulate.
- start  out  1  to MAC: operation start.
- count  out  1  to MAC: multiplier execute window.
- weight  out  DATA_W  to MAC: stationary weight.
- in_value  out  DATA_W  to MAC.
- in_accumulate  out  DATA_W  to MAC.
- out_accumulate  in  DATA_W  from MAC.
- op_count  out  CNT_W  completed operations (see Optional Feature).

Behaviour:
- Clocking and reset: one clock CLK; RST is synchronous and active-high.
- Reset values: every output 0, state IDLE, w_loaded 0, lat_cnt 0.
- Reset mid-operation: aborts the operation, drops any pending result, and clears w_loaded. The weight must be reloaded before the next operation.
- All MAC-side outputs and res_data are registered.
- States: IDLE, ISSUE, WAIT, CAPTURE, RESULT.
- IDLE:
  - op_ready = w_loaded.
  - w_wr in IDLE loads the weight register and sets w_loaded; the weight output updates on the next cycle.
  - If w_wr and op_valid occur in the same cycle: the weight loads and op_ready is evaluated against the old w_loaded. When w_loaded is 1, both take effect and the operation uses the new weight.
  - On op_valid & op_ready (cycle T): latch op_value to in_value and op_acc to in_accumulate, then go to ISSUE.
- ISSUE (cycle T+1):
  - start=1, count=1, lat_cnt=1.
  - Next state is WAIT if MAC_LAT>1, otherwise CAPTURE.
- WAIT:
  - start=0, count=1, lat_cnt increments each cycle.
  - Leaves for CAPTURE when lat_cnt==MAC_LAT, so count is high for exactly MAC_LAT cycles (T+1..T+MAC_LAT).
- CAPTURE (T+MAC_LAT+1):
  - start=0, count=0.
  - out_accumulate is sampled at the end of this cycle into res_data; go to RESULT.
- RESULT:
  - res_valid=1 from T+MAC_LAT+2; res_data is stable while res_valid=1 and res_ready=0.
  - On res_ready: go to IDLE with res_valid=0 the next cycle. There is no result bypass.
- in_value and in_accumulate hold their values until the next accepted operation.
- The weight holds until the next accepted write.
- op_ready is 0 in every state except IDLE.
- w_wr outside IDLE is ignored; w_err pulses high for exactly that cycle.
- Throughput: one operation per MAC_LAT+3 cycles when res_ready is held high.

Optional Feature:
- Macro: SYSTOLIC_MAC_DRIVER_OPCNT_EN.
- Defined: op_count is a free-running CNT_W-bit counter.
  - Increments on each res_valid & res_ready handshake.
  - Wraps from all-ones to 0.
  - Cleared by RST.
- Not defined: op_count is tied to 0 and no counter flops exist.

Decomposition:
- Shared package systolic_pkg:
  - mac_drv_state_t enum (IDLE, ISSUE, WAIT, CAPTURE, RESULT).
  - DATA_W default constant.
  - FP16 constants used by benches: FP16_ONE=16'h3C00, FP16_TWO=16'h4000, FP16_THREE=16'h4200.
- The MAC-side signal bundle is the existing systolic-array MAC interface; this block drives its MAC-facing inputs.
- No sub-module: FSM, latency counter and registers stay in a single module.

Test Plan:
- Weight preload and single operation:
  - Stimulus: RST, then w_wr with 16'h4000; op_value=16'h3C00, op_acc=16'h3C00; mock MAC drives out_accumulate=16'h4200 while count=1; MAC_LAT=3.
  - Required: start high only at T+1; count high T+1..T+3; res_valid at T+5 with res_data=16'h4200.
- No weight loaded:
  - Stimulus: op_valid=1 after reset with no w_wr.
  - Required: op_ready stays 0 for 20 cycles and start never asserts.
- Result backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles; mock MAC changes out_accumulate to 16'h0000.
  - Required: res_data holds 16'h4200; op_ready stays 0; a single handshake on release.
- Busy weight write:
  - Stimulus: w_wr with 16'h3C00 during WAIT.
  - Required: w_err pulses for exactly 1 cycle; the weight output remains 16'h4000.
- Reset mid-operation:
  - Stimulus: RST asserted during WAIT.
  - Required: next cycle all outputs are 0 and state is IDLE; op_ready=0 until a new w_wr.
- Boundary and counter:
  - Stimulus: MAC_LAT=1 with back-to-back operations and res_ready=1.
  - Required: count is high for 1 cycle per operation at an interval of 4 cycles.
  - With SYSTOLIC_MAC_DRIVER_OPCNT_EN and CNT_W=4: op_count reads 0 after 16 completions.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array MAC driver: FSM state encoding,
// default data width and FP16 constants used by PE-level benches.
package systolic_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic [15:0] FP16_ONE   = 16'h3C00;
  localparam logic [15:0] FP16_TWO   = 16'h4000;
  localparam logic [15:0] FP16_THREE = 16'h4200;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESULT
  } mac_drv_state_t;

endpackage

// File: rtl/systolic_mac_driver.sv
// Initiator for one systolic MAC processing element: holds the stationary weight,
// sequences start/count over a fixed MAC_LAT window and returns out_accumulate.
// Optional completed-operation counter enabled by SYSTOLIC_MAC_DRIVER_OPCNT_EN.
module systolic_mac_driver
  import systolic_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int MAC_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              w_wr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_err,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_value,
  input  logic [DATA_W-1:0] op_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              start,
  output logic              count,
  output logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] in_value,
  output logic [DATA_W-1:0] in_accumulate,
  input  logic [DATA_W-1:0] out_accumulate,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [3:0] LAT_END = 4'(MAC_LAT);

  mac_drv_state_t    state_reg, state_next;
  logic [3:0]        lat_cnt_reg, lat_cnt_next;
  logic              w_loaded_reg;
  logic [DATA_W-1:0] weight_reg, in_value_reg, in_acc_reg, res_data_reg;
  logic              start_reg, count_reg, res_valid_reg;
  logic              accept, w_take;

  // op_ready looks only at the registered w_loaded, so a same-cycle weight
  // write cannot enable an operation by itself.
  assign op_ready = (state_reg == IDLE) && w_loaded_reg;
  assign accept   = op_valid && op_ready;
  assign w_take   = w_wr && (state_reg == IDLE);
  assign w_err    = w_wr && (state_reg != IDLE) && !RST;

  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = ISSUE;
          lat_cnt_next = 4'd1;
        end
      end
      ISSUE, WAIT: begin
        if (lat_cnt_reg == LAT_END) begin
          state_next = CAPTURE;
        end else begin
          state_next   = WAIT;
          lat_cnt_next = lat_cnt_reg + 4'd1;
        end
      end
      CAPTURE: state_next = RESULT;
      RESULT: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // MAC-facing strobes are decoded from the next state so they are flop outputs
  // that line up exactly with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      lat_cnt_reg   <= '0;
      w_loaded_reg  <= 1'b0;
      weight_reg    <= '0;
      in_value_reg  <= '0;
      in_acc_reg    <= '0;
      res_data_reg  <= '0;
      start_reg     <= 1'b0;
      count_reg     <= 1'b0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lat_cnt_reg   <= lat_cnt_next;
      start_reg     <= (state_next == ISSUE);
      count_reg     <= (state_next == ISSUE) || (state_next == WAIT);
      res_valid_reg <= (state_next == RESULT);
      if (w_take) begin
        weight_reg   <= w_data;
        w_loaded_reg <= 1'b1;
      end
      if (accept) begin
        in_value_reg <= op_value;
        in_acc_reg   <= op_acc;
      end
      if (state_reg == CAPTURE) res_data_reg <= out_accumulate;
    end
  end

  assign start         = start_reg;
  assign count         = count_reg;
  assign weight        = weight_reg;
  assign in_value      = in_value_reg;
  assign in_accumulate = in_acc_reg;
  assign res_valid     = res_valid_reg;
  assign res_data      = res_data_reg;

`ifdef SYSTOLIC_MAC_DRIVER_OPCNT_EN
  logic [CNT_W-1:0] op_count_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_count_reg <= '0;
    end else if (res_valid_reg && res_ready) begin
      op_count_reg <= op_count_reg + CNT_W'(1);
    end
  end

  assign op_count = op_count_reg;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_systolic_mac_driver.sv
// Self-checking bench for systolic_mac_driver: directed steps plus randomized
// operations against a transaction-level model, on MAC_LAT=3 and MAC_LAT=1 builds.
module tb_systolic_mac_driver;
  import systolic_pkg::*;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int CNT_A = 16;
  localparam int CNT_B = 4;
`ifdef SYSTOLIC_MAC_DRIVER_OPCNT_EN
  localparam bit OPCNT_ON = 1'b1;
`else
  localparam bit OPCNT_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- instance A (MAC_LAT = 3) ----------------
  logic        RST = 1'b1;
  logic        w_wr = 1'b0, op_valid = 1'b0, res_ready = 1'b0;
  logic [15:0] w_data = '0, op_value = '0, op_acc = '0;
  logic        w_err, op_ready, res_valid, start, count;
  logic [15:0] res_data, weight, in_value, in_accumulate, out_accumulate;
  logic [CNT_A-1:0] op_count;

  systolic_mac_driver #(.DATA_W(16), .MAC_LAT(LAT_A), .CNT_W(CNT_A)) dut_a (
    .CLK(CLK), .RST(RST), .w_wr(w_wr), .w_data(w_data), .w_err(w_err),
    .op_valid(op_valid), .op_ready(op_ready), .op_value(op_value), .op_acc(op_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .start(start), .count(count), .weight(weight), .in_value(in_value),
    .in_accumulate(in_accumulate), .out_accumulate(out_accumulate), .op_count(op_count)
  );

  // ---------------- instance B (MAC_LAT = 1, 4-bit counter) ----------------
  logic        rst_b = 1'b1;
  logic        w_wr_b = 1'b0, op_valid_b = 1'b0, res_ready_b = 1'b0;
  logic [15:0] w_data_b = '0, op_value_b = '0, op_acc_b = '0;
  logic        w_err_b, op_ready_b, res_valid_b, start_b, count_b;
  logic [15:0] res_data_b, weight_b, in_value_b, in_accumulate_b, out_accumulate_b;
  logic [CNT_B-1:0] op_count_b;

  systolic_mac_driver #(.DATA_W(16), .MAC_LAT(LAT_B), .CNT_W(CNT_B)) dut_b (
    .CLK(CLK), .RST(rst_b), .w_wr(w_wr_b), .w_data(w_data_b), .w_err(w_err_b),
    .op_valid(op_valid_b), .op_ready(op_ready_b), .op_value(op_value_b), .op_acc(op_acc_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b),
    .start(start_b), .count(count_b), .weight(weight_b), .in_value(in_value_b),
    .in_accumulate(in_accumulate_b), .out_accumulate(out_accumulate_b), .op_count(op_count_b)
  );

  // Stand-in for the PE arithmetic: any function of the three operands will do,
  // except that 2*1+1 returns FP16 three so the directed case reads naturally.
  function automatic logic [15:0] mac_f(input logic [15:0] w, input logic [15:0] v,
                                        input logic [15:0] a);
    if (w == FP16_TWO && v == FP16_ONE && a == FP16_ONE) return FP16_THREE;
    return (w ^ {v[7:0], v[15:8]}) + a;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n, input int w);
    return OPCNT_ON ? 32'(n % (1 << w)) : 32'd0;
  endfunction

  // Mock PEs: result appears after start and is cleared to zero once the
  // capture cycle is over, so a late capture is visible.
  logic [15:0] mac_out_a, mac_out_b;
  logic        count_q_a, count_q_b;

  always @(posedge CLK) begin
    if (RST) begin
      mac_out_a <= '0;
      count_q_a <= 1'b0;
    end else begin
      count_q_a <= count;
      if (start) mac_out_a <= mac_f(weight, in_value, in_accumulate);
      else if (count_q_a && !count) mac_out_a <= 16'h0000;
    end
  end

  always @(posedge CLK) begin
    if (rst_b) begin
      mac_out_b <= '0;
      count_q_b <= 1'b0;
    end else begin
      count_q_b <= count_b;
      if (start_b) mac_out_b <= mac_f(weight_b, in_value_b, in_accumulate_b);
      else if (count_q_b && !count_b) mac_out_b <= 16'h0000;
    end
  end

  assign out_accumulate   = mac_out_a;
  assign out_accumulate_b = mac_out_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model state for instance A
  logic [15:0] w_model = '0;
  int          done_a = 0;

  // One complete operation on A with per-cycle timing checks relative to accept cycle T.
  task automatic do_op_a(input logic wr, input logic [15:0] wv, input logic [15:0] v,
                         input logic [15:0] a, input int bp, input logic busy);
    logic [15:0] exp_res;
    @(negedge CLK);
    w_wr = wr; w_data = wv; op_valid = 1'b1; op_value = v; op_acc = a; res_ready = 1'b0;
    #1;
    check("op_ready_idle", 32'(op_ready), 32'd1);
    if (wr) w_model = wv;
    exp_res = mac_f(w_model, v, a);
    for (int k = 1; k <= LAT_A + 2; k++) begin
      @(negedge CLK);
      w_wr = busy && (k == 2); w_data = ~w_model;
      op_valid = 1'($urandom_range(0, 1)); op_value = 16'($urandom); op_acc = 16'($urandom);
      #1;
      check("start", 32'(start), 32'(k == 1));
      check("count", 32'(count), 32'(k <= LAT_A));
      check("res_valid_lat", 32'(res_valid), 32'(k == LAT_A + 2));
      check("op_ready_busy", 32'(op_ready), 32'd0);
      check("w_err", 32'(w_err), 32'(busy && (k == 2)));
      check("weight_hold", 32'(weight), 32'(w_model));
      check("in_value", 32'(in_value), 32'(v));
      check("in_accumulate", 32'(in_accumulate), 32'(a));
    end
    check("res_data", 32'(res_data), 32'(exp_res));
    for (int b = 0; b < bp; b++) begin
      @(negedge CLK);
      w_wr = 1'b0; op_valid = 1'b0;
      #1;
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_data", 32'(res_data), 32'(exp_res));
      check("bp_op_ready", 32'(op_ready), 32'd0);
    end
    @(negedge CLK);
    w_wr = 1'b0; op_valid = 1'b0; res_ready = 1'b1;
    #1;
    check("hs_res_valid", 32'(res_valid), 32'd1);
    check("hs_res_data", 32'(res_data), 32'(exp_res));
    check("op_count_a", 32'(op_count), exp_cnt(done_a, CNT_A));
    done_a++;
    @(negedge CLK);
    res_ready = 1'b0;
    #1;
    check("post_res_valid", 32'(res_valid), 32'd0);
    check("post_op_ready", 32'(op_ready), 32'd1);
    check("op_count_a_post", 32'(op_count), exp_cnt(done_a, CNT_A));
    $display("op A %0d: w=%h v=%h a=%h bp=%0d busy_wr=%0d res=%h", done_a, w_model, v, a,
             bp, busy, res_data);
  endtask

  task automatic check_all_zero_a(input string tag);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_weight"}, 32'(weight), 32'd0);
    check({tag, "_in_value"}, 32'(in_value), 32'd0);
    check({tag, "_in_acc"}, 32'(in_accumulate), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    check({tag, "_w_err"}, 32'(w_err), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] wb_model;
  logic [15:0] exp_b;
  int hs_b, last_rise;
  logic prev_cnt;

  initial begin
    // Reset values
    repeat (3) @(negedge CLK);
    #1;
    check_all_zero_a("reset");

    // No weight loaded: operand offered but never accepted
    @(negedge CLK);
    RST = 1'b0; op_valid = 1'b1; op_value = FP16_ONE; op_acc = FP16_ONE;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #1;
      check("noweight_op_ready", 32'(op_ready), 32'd0);
      check("noweight_start", 32'(start), 32'd0);
    end

    // Weight preload
    @(negedge CLK);
    op_valid = 1'b0; w_wr = 1'b1; w_data = FP16_TWO;
    #1;
    check("preload_w_err", 32'(w_err), 32'd0);
    @(negedge CLK);
    w_wr = 1'b0;
    #1;
    w_model = FP16_TWO;
    check("preload_weight", 32'(weight), 32'(FP16_TWO));
    check("preload_op_ready", 32'(op_ready), 32'd1);

    // Directed op with 10 cycles of backpressure, then a busy weight write
    do_op_a(1'b0, 16'h0000, FP16_ONE, FP16_ONE, 10, 1'b0);
    do_op_a(1'b0, 16'h0000, FP16_ONE, FP16_TWO, 2, 1'b1);
    // Weight write coincident with an accepted operand
    do_op_a(1'b1, FP16_THREE, FP16_TWO, FP16_ONE, 0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      do_op_a(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset during WAIT
    @(negedge CLK);
    op_valid = 1'b1; op_value = 16'h1234; op_acc = 16'h5678;
    @(negedge CLK);
    op_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; op_valid = 1'b1;
    #1;
    check_all_zero_a("midreset");
    done_a = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      check("midreset_op_ready", 32'(op_ready), 32'd0);
      check("midreset_start", 32'(start), 32'd0);
    end
    @(negedge CLK);
    op_valid = 1'b0; w_wr = 1'b1; w_data = FP16_ONE;
    @(negedge CLK);
    w_wr = 1'b0;
    w_model = FP16_ONE;
    do_op_a(1'b0, 16'h0000, FP16_THREE, FP16_TWO, 1, 1'b0);

    // Instance B: MAC_LAT=1, back-to-back with res_ready held high
    @(negedge CLK);
    rst_b = 1'b0; w_wr_b = 1'b1; wb_model = 16'($urandom); w_data_b = wb_model;
    @(negedge CLK);
    w_wr_b = 1'b0;
    hs_b = 0; last_rise = -1; prev_cnt = 1'b0;
    for (int i = 0; i < 200 && hs_b < 16; i++) begin
      @(negedge CLK);
      op_valid_b = 1'b1; res_ready_b = 1'b1;
      op_value_b = 16'($urandom); op_acc_b = 16'($urandom);
      #1;
      if (op_valid_b && op_ready_b) exp_q.push_back(mac_f(wb_model, op_value_b, op_acc_b));
      if (count_b) begin
        check("b_count_width", 32'(prev_cnt), 32'd0);
        if (last_rise >= 0) check("b_count_interval", 32'(cyc - last_rise), 32'(LAT_B + 3));
        last_rise = cyc;
      end
      prev_cnt = count_b;
      if (res_valid_b && res_ready_b) begin
        check("b_result_pending", 32'(exp_q.size() > 0), 32'd1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        check("b_res_data", 32'(res_data_b), 32'(exp_b));
        check("b_op_count", 32'(op_count_b), exp_cnt(hs_b, CNT_B));
        check("b_w_err", 32'(w_err_b), 32'd0);
        hs_b++;
        $display("op B %0d: res=%h op_count=%0d", hs_b, res_data_b, op_count_b);
      end
    end
    @(negedge CLK);
    op_valid_b = 1'b0; res_ready_b = 1'b0;
    #1;
    check("b_handshakes", 32'(hs_b), 32'd16);
    check("b_queue_empty", 32'(exp_q.size()), 32'd0);
    check("b_op_count_wrap", 32'(op_count_b), exp_cnt(hs_b, CNT_B));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
